// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared BCD digit type, 7-segment patterns and the BCD-to-segment lookup
package bcd_disp_pkg;
  typedef logic [3:0] bcd_t;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  function automatic logic [6:0] bcd_to_seg(input bcd_t d);
    return (d > 4'd9) ? SEG_BLANK : SEG_DIGIT[d];
  endfunction
endpackage

// File: rtl/bcd_counter_display_if.sv
// bcd_counter_display_if: board-pin bundle (keys in; seg, dig, count_bcd, ovf out); master = counter side
interface bcd_disp_if #(parameter int NDIG = 4);
  logic key_up_n;
  logic key_dn_n;
  logic [7:0] seg;
  logic [NDIG-1:0] dig;
  logic [4*NDIG-1:0] count_bcd;
  logic ovf;
  modport master (input key_up_n, key_dn_n, output seg, dig, count_bcd, ovf);
  modport slave (output key_up_n, key_dn_n, input seg, dig, count_bcd, ovf);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: clk, rst, tick, key_n (raw, active-low) in; press = one-clk pulse when a debounced press is accepted
module key_debounce #(
  parameter int DEB_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_n,
  output logic press
);
  logic sync1_q, sync2_q, stable_q, stable_d;
  logic [3:0] run_q, run_d;
  always_comb begin
    stable_d = stable_q;
    run_d = run_q;
    press = 1'b0;
    if (tick) begin
      if (sync2_q == stable_q) run_d = '0;
      else if (run_q == 4'(DEB_TICKS - 1)) begin
        stable_d = sync2_q;
        run_d = '0;
        press = ~sync2_q;
      end else run_d = run_q + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      stable_q <= 1'b1;
      run_q <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/bcd_counter_display.sv
// bcd_counter_display: clk, rst, bus (keys in; seg, dig, count_bcd, ovf out) -- debounced BCD up/down counter with scanned display
module bcd_counter_display
  import bcd_disp_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int TICK_DIV = 67500,
  parameter int DEB_TICKS = 4,
  parameter int BLANK_LZ = 1
) (
  input logic clk,
  input logic rst,
  bcd_disp_if.master bus
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  logic [TW-1:0] tick_q, tick_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NDIG-1:0] count_q, count_d, inc_v, dec_v;
  logic [NDIG-1:0] dig_q, dig_d;
  logic [7:0] seg_q, seg_d;
  logic tick, up, dn, ovf_q, ovf_d, all9, all0, hi_zero;
  bcd_t cur;
  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_up (.clk, .rst, .tick, .key_n(bus.key_up_n), .press(up));
  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_dn (.clk, .rst, .tick, .key_n(bus.key_dn_n), .press(dn));
  always_comb begin
    tick = tick_q == TW'(TICK_DIV - 1);
    tick_d = tick ? '0 : tick_q + TW'(1);
    all9 = 1'b1;
    all0 = 1'b1;
    inc_v = count_q;
    dec_v = count_q;
    for (int i = 0; i < NDIG; i++) begin
      inc_v[4*i+:4] = all9 ? (count_q[4*i+:4] == 4'd9 ? 4'd0 : count_q[4*i+:4] + 4'd1) : count_q[4*i+:4];
      dec_v[4*i+:4] = all0 ? (count_q[4*i+:4] == 4'd0 ? 4'd9 : count_q[4*i+:4] - 4'd1) : count_q[4*i+:4];
      all9 = all9 && count_q[4*i+:4] == 4'd9;
      all0 = all0 && count_q[4*i+:4] == 4'd0;
    end
    count_d = (up && !dn) ? inc_v : (dn && !up) ? dec_v : count_q;
    ovf_d = ovf_q | (up & ~dn & all9) | (dn & ~up & all0);
    idx_d = tick ? (idx_q == IW'(NDIG - 1) ? '0 : idx_q + IW'(1)) : idx_q;
    cur = count_d[4*idx_d+:4];
    hi_zero = 1'b1;
    for (int i = 0; i < NDIG; i++)
      if (i >= int'(idx_d) && count_d[4*i+:4] != 4'd0) hi_zero = 1'b0;
    dig_d = ~(NDIG'(1) << idx_d);
    seg_d = {idx_d == '0 ? ovf_d : 1'b0,
             (BLANK_LZ != 0 && idx_d != '0 && hi_zero) ? SEG_BLANK : bcd_to_seg(cur)};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      idx_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      dig_q <= ~NDIG'(1);
      seg_q <= 8'h3F;
    end else begin
      tick_q <= tick_d;
      idx_q <= idx_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      dig_q <= dig_d;
      seg_q <= seg_d;
    end
  end
  assign bus.count_bcd = count_q;
  assign bus.ovf = ovf_q;
  assign bus.dig = dig_q;
  assign bus.seg = seg_q;
endmodule

// File: tb/tb_bcd_counter_display.sv
// tb_bcd_counter_display: directed and random key presses on a 4-digit and a 2-digit counter against an arithmetic model
module tb_bcd_counter_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up_n = 1'b1;
  logic dn_n = 1'b1;
  int tests = 0;
  int fails = 0;
  int m1 = 0;
  int m2 = 0;
  bit o1 = 1'b0;
  bit o2 = 1'b0;
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  bcd_disp_if #(.NDIG(4)) b1 ();
  bcd_disp_if #(.NDIG(2)) b2 ();
  assign b1.key_up_n = up_n;
  assign b1.key_dn_n = dn_n;
  assign b2.key_up_n = up_n;
  assign b2.key_dn_n = dn_n;
  bcd_counter_display #(.NDIG(4), .TICK_DIV(4), .DEB_TICKS(3), .BLANK_LZ(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  bcd_counter_display #(.NDIG(2), .TICK_DIV(4), .DEB_TICKS(3), .BLANK_LZ(1)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i+:4] = 4'((v / p) % 10);
      p *= 10;
    end
    return r;
  endfunction
  task automatic model(input bit u, input bit d);
    if (u && !d) begin
      o1 |= (m1 == 9999);
      o2 |= (m2 == 99);
      m1 = (m1 + 1) % 10000;
      m2 = (m2 + 1) % 100;
    end else if (d && !u) begin
      o1 |= (m1 == 0);
      o2 |= (m2 == 0);
      m1 = (m1 + 9999) % 10000;
      m2 = (m2 + 99) % 100;
    end
  endtask
  task automatic chk_state(input string tag);
    logic [15:0] e2;
    e2 = to_bcd(m2);
    chk({tag, " cnt4"}, 32'(b1.count_bcd), 32'(to_bcd(m1)));
    chk({tag, " ovf4"}, 32'(b1.ovf), 32'(o1));
    chk({tag, " cnt2"}, 32'(b2.count_bcd), 32'(e2[7:0]));
    chk({tag, " ovf2"}, 32'(b2.ovf), 32'(o2));
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m1 = 0; m2 = 0; o1 = 1'b0; o2 = 1'b0;
  endtask
  task automatic press(input bit u, input bit d, input string tag);
    @(negedge clk);
    up_n = !u;
    dn_n = !d;
    repeat (24) @(negedge clk);
    up_n = 1'b1;
    dn_n = 1'b1;
    repeat (24) @(negedge clk);
    model(u, d);
    chk_state(tag);
  endtask
  task automatic scan_chk(input string tag);
    logic [3:0] seen;
    int k, p, dv;
    logic [7:0] es;
    seen = '0;
    repeat (16) begin
      @(negedge clk);
      k = -1;
      for (int j = 0; j < 4; j++) if (b1.dig == ~(4'b1 << j)) k = j;
      chk({tag, " dig onehot"}, 32'(k >= 0), 32'(1));
      if (k >= 0) begin
        seen[k] = 1'b1;
        p = 1;
        for (int j = 0; j < k; j++) p *= 10;
        dv = (m1 / p) % 10;
        es = {(k == 0) ? o1 : 1'b0, (k > 0 && m1 / p == 0) ? 7'h00 : segtab[dv]};
        chk({tag, " seg"}, 32'(b1.seg), 32'(es));
      end
    end
    chk({tag, " all digits scanned"}, 32'(seen), 32'hF);
  endtask
  initial begin
    do_reset();
    chk("reset dig4", 32'(b1.dig), 32'hE);
    chk("reset seg4", 32'(b1.seg), 32'h3F);
    chk("reset dig2", 32'(b2.dig), 32'h2);
    chk("reset seg2", 32'(b2.seg), 32'h3F);
    repeat (10) @(negedge clk);
    chk_state("reset");
    for (int i = 0; i < 12; i++) begin
      up_n = ~up_n;
      repeat (5) @(negedge clk);
    end
    chk_state("bounce rejected");
    up_n = 1'b0;
    repeat (24) @(negedge clk);
    model(1'b1, 1'b0);
    chk_state("bounce then hold");
    repeat (40) @(negedge clk);
    chk_state("hold no repeat");
    up_n = 1'b1;
    repeat (24) @(negedge clk);
    chk_state("release no event");
    do_reset();
    for (int i = 0; i < 99; i++) press(1'b1, 1'b0, "up run");
    press(1'b1, 1'b0, "up wrap2 carry4");
    press(1'b0, 1'b1, "down borrow");
    press(1'b1, 1'b1, "simultaneous");
    do_reset();
    press(1'b0, 1'b1, "down wrap");
    scan_chk("scan 9999 ovf");
    press(1'b1, 1'b0, "up wrap4");
    scan_chk("scan 0000 dp");
    do_reset();
    for (int i = 0; i < 42; i++) press(1'b1, 1'b0, "to 42");
    scan_chk("scan 0042");
    @(negedge clk);
    up_n = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m1 = 0; m2 = 0; o1 = 1'b0; o2 = 1'b0;
    chk_state("held through reset");
    repeat (24) @(negedge clk);
    model(1'b1, 1'b0);
    chk_state("held key after reset");
    up_n = 1'b1;
    repeat (24) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0, 1: press(1'b1, 1'b0, "rand up");
        2: press(1'b0, 1'b1, "rand dn");
        default: press(1'b1, 1'b1, "rand both");
      endcase
    end
    scan_chk("scan random");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
